// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, opcode constants and the IEEE 1149.1 TMS transition table
package jtag_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RTI        = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_e;

  localparam int IR_IDCODE    = 1;
  localparam int IR_USER_BASE = 2;

  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    case (s)
      TLR:        return tms ? TLR       : RTI;
      RTI:        return tms ? SELECT_DR : RTI;
      SELECT_DR:  return tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: return tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   return tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   return tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   return tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   return tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  return tms ? SELECT_DR : RTI;
      SELECT_IR:  return tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: return tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   return tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   return tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   return tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   return tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  return tms ? SELECT_DR : RTI;
      default:    return TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: multi-flop synchroniser for the JTAG pins; bit 0 is tck and yields rise/fall strobes
module jtag_pin_sync #(
  parameter int N      = 3,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pins,
  output logic [N-1:0] pins_s,
  output logic         tck_rise,
  output logic         tck_fall
);
  logic [STAGES-1:0][N-1:0] q;
  logic tck_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      q     <= '0;
      tck_q <= 1'b0;
    end else begin
      q     <= {q[STAGES-2:0], pins};
      tck_q <= q[STAGES-1][0];
    end
  assign pins_s   = q[STAGES-1];
  assign tck_rise = pins_s[0] & ~tck_q;
  assign tck_fall = ~pins_s[0] & tck_q;
endmodule

// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: system-clock oversampled TAP with IDCODE, BYPASS and user DRs.
// JTAG_TRST_EN adds a synchronised trst_n input forcing Test-Logic-Reset.
module jtag_tap_oversampled
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE        = 32'h1000_0CE5,
  parameter int          NUM_USER_DR   = 2,
  parameter int          USER_DR_WIDTH = 8,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 tck,
  input  logic                                 tms,
  input  logic                                 tdi,
`ifdef JTAG_TRST_EN
  input  logic                                 trst_n,
`endif
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0] user_capture,
  output logic                                 tdo,
  output logic                                 tdo_oe,
  output logic [USER_DR_WIDTH-1:0]             user_update,
  output logic [NUM_USER_DR-1:0]               user_update_sel,
  output logic [IR_WIDTH-1:0]                  ir_value,
  output logic [3:0]                           tap_state
);
  tap_state_e state;
  logic [31:0] sr, cap, shifted;
  logic [NUM_USER_DR-1:0] uhot;
  logic [5:0] len;
  logic [4:0] sh;
  logic tck_rise, tck_fall, tms_s, tdi_s, trst_s, shifting;
`ifdef JTAG_TRST_EN
  logic [3:0] pins_s;
  // trst is inverted before syncing so the cleared synchroniser reads as "not asserted"
  jtag_pin_sync #(.N(4), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .pins({~trst_n, tdi, tms, tck}),
    .pins_s(pins_s), .tck_rise(tck_rise), .tck_fall(tck_fall)
  );
  assign trst_s = pins_s[3];
`else
  logic [2:0] pins_s;
  jtag_pin_sync #(.N(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .pins({tdi, tms, tck}),
    .pins_s(pins_s), .tck_rise(tck_rise), .tck_fall(tck_fall)
  );
  assign trst_s = 1'b0;
`endif
  assign tms_s     = pins_s[1];
  assign tdi_s     = pins_s[2];
  assign tap_state = state;
  assign shifting  = state == SHIFT_IR || state == SHIFT_DR;
  always_comb begin
    uhot = '0;
    cap  = ir_value == IR_WIDTH'(IR_IDCODE) ? IDCODE : 32'd0;
    len  = ir_value == IR_WIDTH'(IR_IDCODE) ? 6'd32 : 6'd1;
    for (int k = 0; k < NUM_USER_DR; k++)
      if (int'(ir_value) == IR_USER_BASE + k) begin
        uhot[k] = 1'b1;
        cap     = 32'(user_capture[k*USER_DR_WIDTH +: USER_DR_WIDTH]);
        len     = 6'(USER_DR_WIDTH);
      end
    if (state == SHIFT_IR) len = 6'(IR_WIDTH);
    sh      = 5'(len - 6'd1);
    // shared register: tdi enters at the top of the active chain, bits above it stay clear
    shifted = (32'(tdi_s) << sh) | ((sr >> 1) & ((32'd1 << sh) - 32'd1));
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state           <= TLR;
      ir_value        <= IR_WIDTH'(IR_IDCODE);
      sr              <= '0;
      tdo             <= 1'b0;
      tdo_oe          <= 1'b0;
      user_update     <= '0;
      user_update_sel <= '0;
    end else begin
      user_update_sel <= '0;
      if (trst_s) begin
        state    <= TLR;
        ir_value <= IR_WIDTH'(IR_IDCODE);
        tdo_oe   <= 1'b0;
      end else if (tck_rise) begin
        state <= next_state(state, tms_s);
        if (next_state(state, tms_s) == TLR) ir_value <= IR_WIDTH'(IR_IDCODE);
        if (state == CAPTURE_IR) sr <= 32'd1;
        if (state == CAPTURE_DR) sr <= cap;
        if (shifting) sr <= shifted;
      end else if (tck_fall) begin
        tdo_oe <= shifting;
        if (shifting) tdo <= sr[0];
        if (state == UPDATE_IR) ir_value <= sr[IR_WIDTH-1:0];
        if (state == UPDATE_DR && |uhot) begin
          user_update     <= sr[USER_DR_WIDTH-1:0];
          user_update_sel <= uhot;
        end
      end
    end
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: randomized scans checked against a bit-stream model of the TAP registers
module tb_jtag_tap_oversampled;
  import jtag_pkg::*;
  localparam int IRW = 4, NU = 2, UW = 8, UCW = NU*UW, HOLD = 4;
  localparam logic [31:0] IDC = 32'h1000_0CE5;

  logic clk = 0, rst_n = 0, tck = 0, tms = 0, tdi = 0;
`ifdef JTAG_TRST_EN
  logic trst_n = 1;
`endif
  logic [UCW-1:0] user_capture = '0;
  logic tdo, tdo_oe;
  logic [UW-1:0] user_update;
  logic [NU-1:0] user_update_sel, last_sel = '0;
  logic [IRW-1:0] ir_value;
  logic [3:0] tap_state;
  int checks = 0, errors = 0, pulses = 0;

  always #5 clk = ~clk;

  jtag_tap_oversampled #(.IR_WIDTH(IRW), .IDCODE(IDC), .NUM_USER_DR(NU), .USER_DR_WIDTH(UW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_TRST_EN
    .trst_n(trst_n),
`endif
    .user_capture(user_capture), .tdo(tdo), .tdo_oe(tdo_oe), .user_update(user_update),
    .user_update_sel(user_update_sel), .ir_value(ir_value), .tap_state(tap_state)
  );

  // counts clk cycles in which any update strobe is high
  always @(negedge clk) if (|user_update_sel) begin pulses++; last_sel = user_update_sel; end

  function automatic int exp_len(input logic [IRW-1:0] ir);
    if (ir == 1) return 32;
    if (ir >= 2 && ir < 2 + NU) return UW;
    return 1;
  endfunction

  // bits seen on tdo in order: captured value (len bits) followed by every tdi bit shifted in
  function automatic logic [127:0] stream(input logic [IRW-1:0] ir, input logic [63:0] din);
    logic [31:0] c;
    c = 0;
    if (ir == 1) c = IDC;
    if (ir >= 2 && ir < 2 + NU) c = 32'(user_capture[(int'(ir) - 2)*UW +: UW]);
    return (128'(din) << exp_len(ir)) | 128'(c);
  endfunction

  task automatic tick(input logic m, input logic d, output logic o, output logic e);
    tms = m; tdi = d;
    repeat (HOLD) @(negedge clk);
    tck = 1;
    repeat (HOLD) @(negedge clk);
    tck = 0;
    repeat (HOLD) @(negedge clk);
    o = tdo; e = tdo_oe;
  endtask

  task automatic scan_ir(input logic [IRW-1:0] v, output logic [IRW-1:0] cout);
    logic o, e;
    tick(1, 0, o, e); tick(1, 0, o, e); tick(0, 0, o, e); tick(0, 0, o, e);
    cout[0] = o;
    for (int i = 0; i < IRW; i++) begin
      tick(i == IRW - 1, v[i], o, e);
      if (i < IRW - 1) cout[i+1] = o;
    end
    tick(1, 0, o, e); tick(0, 0, o, e);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout, output logic oe_ok);
    logic o, e;
    dout = '0;
    tick(1, 0, o, e); tick(0, 0, o, e);
    oe_ok = !e;
    tick(0, 0, o, e);
    dout[0] = o; oe_ok &= e;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], o, e);
      if (i < n - 1) begin dout[i+1] = o; oe_ok &= e; end
      else oe_ok &= !e;
    end
    tick(1, 0, o, e); tick(0, 0, o, e);
  endtask

  task automatic test_reset;
    logic o, e;
    logic [IRW-1:0] c;
    rst_n = 0;
    repeat (5) @(negedge clk);
    checks += 6;
    if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL reset_state got %h want %h", tap_state, 4'(TLR)); end
    if (ir_value !== 4'd1) begin errors++; $display("FAIL reset_ir got %h want 1", ir_value); end
    if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b want 0", tdo); end
    if (tdo_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", tdo_oe); end
    if (user_update !== '0) begin errors++; $display("FAIL reset_upd got %h want 0", user_update); end
    if (user_update_sel !== '0) begin errors++; $display("FAIL reset_sel got %b want 0", user_update_sel); end
    rst_n = 1;
    repeat (3) @(negedge clk);
    tick(0, 0, o, e);
    checks++;
    if (tap_state !== 4'(RTI)) begin errors++; $display("FAIL idle_state got %h want %h", tap_state, 4'(RTI)); end
    scan_ir(4'd2, c);
    checks++;
    if (ir_value !== 4'd2) begin errors++; $display("FAIL ir_load got %h want 2", ir_value); end
    for (int i = 0; i < 5; i++) tick(1, 0, o, e);
    checks += 3;
    if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL tms_reset_state got %h want %h", tap_state, 4'(TLR)); end
    if (ir_value !== 4'd1) begin errors++; $display("FAIL tms_reset_ir got %h want 1", ir_value); end
    if (e !== 1'b0) begin errors++; $display("FAIL tms_reset_oe got %b want 0", e); end
    tick(0, 0, o, e);
  endtask

  task automatic test_idcode;
    logic [63:0] din, dout;
    logic ok;
    din = {$urandom, $urandom};
    scan_dr(32, din, dout, ok);
    checks += 2;
    if (dout !== 64'(IDC)) begin errors++; $display("FAIL idcode got %h want %h", dout, IDC); end
    if (ok !== 1'b1) begin errors++; $display("FAIL idcode_oe got %b want 1", ok); end
  endtask

  task automatic test_bypass;
    logic [IRW-1:0] c;
    logic [63:0] dout;
    logic ok;
    scan_ir(4'hF, c);
    checks += 4;
    if (c !== 4'b0001) begin errors++; $display("FAIL bypass_ircap got %b want 0001", c); end
    if (ir_value !== 4'hF) begin errors++; $display("FAIL bypass_ir got %h want f", ir_value); end
    scan_dr(9, 64'hA5, dout, ok);
    if (dout !== 64'h14A) begin errors++; $display("FAIL bypass_a5 got %h want 14a", dout); end
    if (ok !== 1'b1) begin errors++; $display("FAIL bypass_oe got %b want 1", ok); end
  endtask

  task automatic test_user;
    logic [IRW-1:0] c;
    logic [63:0] dout;
    logic ok;
    int p0;
    scan_ir(4'd2, c);
    user_capture = {8'h00, 8'h5A};
    p0 = pulses;
    scan_dr(8, 64'h3C, dout, ok);
    checks += 5;
    if (dout !== 64'h5A) begin errors++; $display("FAIL user_tdo got %h want 5a", dout); end
    if (user_update !== 8'h3C) begin errors++; $display("FAIL user_upd got %h want 3c", user_update); end
    if (pulses !== p0 + 1) begin errors++; $display("FAIL user_pulse got %0d want %0d", pulses - p0, 1); end
    if (last_sel !== 2'b01) begin errors++; $display("FAIL user_sel got %b want 01", last_sel); end
    if (ok !== 1'b1) begin errors++; $display("FAIL user_oe got %b want 1", ok); end
  endtask

  task automatic test_random;
    logic [IRW-1:0] v, c;
    logic [63:0] din, dout;
    logic [127:0] x;
    logic [NU-1:0] es;
    logic ok;
    int n, p0;
    for (int it = 0; it < 16; it++) begin
      v = IRW'($urandom);
      scan_ir(v, c);
      checks += 2;
      if (c !== 4'b0001) begin errors++; $display("FAIL rnd_ircap got %b want 0001", c); end
      if (ir_value !== v) begin errors++; $display("FAIL rnd_ir got %h want %h", ir_value, v); end
      user_capture = UCW'($urandom);
      n = $urandom_range(exp_len(v) + 8, 1);
      din = {$urandom, $urandom};
      x = stream(v, din);
      p0 = pulses;
      scan_dr(n, din, dout, ok);
      checks += 2;
      if (dout !== 64'(x & ((128'd1 << n) - 1))) begin errors++; $display("FAIL rnd_tdo ir=%h n=%0d got %h want %h", v, n, dout, 64'(x & ((128'd1 << n) - 1))); end
      if (ok !== 1'b1) begin errors++; $display("FAIL rnd_oe got %b want 1", ok); end
      if (v >= 2 && v < 2 + NU) begin
        es = '0; es[v-2] = 1'b1;
        checks += 3;
        if (user_update !== UW'(x >> n)) begin errors++; $display("FAIL rnd_upd got %h want %h", user_update, UW'(x >> n)); end
        if (pulses !== p0 + 1) begin errors++; $display("FAIL rnd_pulse got %0d want 1", pulses - p0); end
        if (last_sel !== es) begin errors++; $display("FAIL rnd_sel got %b want %b", last_sel, es); end
      end else begin
        checks++;
        if (pulses !== p0) begin errors++; $display("FAIL rnd_nopulse got %0d want 0", pulses - p0); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [IRW-1:0] c;
    logic o, e;
    int p0;
    scan_ir(4'd3, c);
    p0 = pulses;
    tick(1, 0, o, e); tick(0, 0, o, e); tick(0, 0, o, e);
    for (int i = 0; i < 3; i++) tick(0, 1'($urandom), o, e);
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL mid_state got %h want %h", tap_state, 4'(TLR)); end
    if (ir_value !== 4'd1) begin errors++; $display("FAIL mid_ir got %h want 1", ir_value); end
    if (tdo_oe !== 1'b0) begin errors++; $display("FAIL mid_oe got %b want 0", tdo_oe); end
    if (tdo !== 1'b0) begin errors++; $display("FAIL mid_tdo got %b want 0", tdo); end
    if (user_update !== '0) begin errors++; $display("FAIL mid_upd got %h want 0", user_update); end
    rst_n = 1;
    repeat (6) @(negedge clk);
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL mid_nopulse got %0d want 0", pulses - p0); end
    tick(0, 0, o, e);
  endtask

`ifdef JTAG_TRST_EN
  task automatic test_trst;
    logic [IRW-1:0] c;
    logic [UW-1:0] uu;
    logic o, e;
    int p0;
    scan_ir(4'd2, c);
    uu = user_update;
    p0 = pulses;
    tick(1, 0, o, e); tick(0, 0, o, e); tick(0, 0, o, e);
    for (int i = 0; i < 3; i++) tick(0, 1'($urandom), o, e);
    trst_n = 0;
    repeat (HOLD) @(negedge clk);
    trst_n = 1;
    repeat (HOLD) @(negedge clk);
    checks += 5;
    if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL trst_state got %h want %h", tap_state, 4'(TLR)); end
    if (ir_value !== 4'd1) begin errors++; $display("FAIL trst_ir got %h want 1", ir_value); end
    if (tdo_oe !== 1'b0) begin errors++; $display("FAIL trst_oe got %b want 0", tdo_oe); end
    if (user_update !== uu) begin errors++; $display("FAIL trst_upd got %h want %h", user_update, uu); end
    if (pulses !== p0) begin errors++; $display("FAIL trst_nopulse got %0d want 0", pulses - p0); end
    tick(0, 0, o, e);
  endtask
`endif

  initial begin
    test_reset;
    test_idcode;
    test_bypass;
    test_user;
    test_random;
    test_reset_mid;
`ifdef JTAG_TRST_EN
    test_trst;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
